// File: rtl/cobra_pkg.sv
// ============================================================================
// Module : cobra_pkg
// Brief  : Direction encodings, direction type and opposite-direction helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cobra_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_RIGHT = 2'b11;

  // Opposite pairs differ only in the LSB: up/down, left/right.
  function automatic dir_t opposite_dir(input dir_t d);
    return d ^ 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cobra_dir_canal.sv
// ============================================================================
// Module : cobra_dir_canal
// Brief  : One snake channel - button edge detect, turn acceptance, turn queue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cobra_dir_canal
  import cobra_pkg::*;
#(
  parameter int   DEPTH     = 3,
  parameter dir_t RESET_DIR = DIR_RIGHT,
  parameter int   LW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    btn_n,
  input  logic          move_tick,
  output dir_t          dir,
  output logic          dir_changed,
  output logic          turn_dropped,
  output logic [LW-1:0] level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    r_btn_prev;
  dir_t          r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [LW-1:0] r_level;
  dir_t          r_dir;
  logic          r_changed;
  logic          r_dropped;

  logic [3:0]    w_press;
  logic          w_have;
  dir_t          w_sel;
  logic [PW-1:0] w_tail_idx;
  dir_t          w_ref;
  logic          w_full;
  logic          w_pop;
  logic          w_legal;
  logic          w_push;
  logic          w_drop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_press = r_btn_prev & ~btn_n;
  assign w_have  = |w_press;

  always_comb begin
    w_sel = DIR_UP;
    if (w_press[0])      w_sel = DIR_UP;
    else if (w_press[1]) w_sel = DIR_DOWN;
    else if (w_press[2]) w_sel = DIR_LEFT;
    else if (w_press[3]) w_sel = DIR_RIGHT;
  end

  // Acceptance is judged against the newest queued turn, i.e. the pre-pop tail.
  assign w_tail_idx = (r_tail == '0) ? PW'(DEPTH - 1) : r_tail - 1'b1;
  assign w_ref      = (r_level != '0) ? r_mem[w_tail_idx] : r_dir;
  assign w_full     = (r_level == LW'(DEPTH));
  assign w_pop      = move_tick && (r_level != '0);
  assign w_legal    = (w_sel != w_ref) && (w_sel != opposite_dir(w_ref));
  assign w_push     = w_have && w_legal && (!w_full || move_tick);
  assign w_drop     = w_have && !w_push;

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_tail] <= w_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_prev <= '1;
      r_head     <= '0;
      r_tail     <= '0;
      r_level    <= '0;
      r_dir      <= RESET_DIR;
      r_changed  <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_btn_prev <= btn_n;
      r_changed  <= w_pop;
      r_dropped  <= w_drop;
      if (w_pop) begin
        r_dir  <= r_mem[r_head];
        r_head <= bump(r_head);
      end
      if (w_push) r_tail <= bump(r_tail);
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  assign dir          = r_dir;
  assign dir_changed  = r_changed;
  assign turn_dropped = r_dropped;
  assign level        = r_level;

endmodule

`default_nettype wire

// File: rtl/cobra_dir_fila.sv
// ============================================================================
// Module : cobra_dir_fila
// Brief  : Multi-player snake direction queue; one independent channel each.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cobra_dir_fila
  import cobra_pkg::*;
#(
  parameter int         NUM_PLAYERS = 2,
  parameter int         DEPTH       = 3,
  parameter logic [1:0] RESET_DIR   = 2'b11
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [4*NUM_PLAYERS-1:0]               btn_n,
  input  logic                                   move_tick,
  output logic [2*NUM_PLAYERS-1:0]               dir,
  output logic [NUM_PLAYERS-1:0]                 dir_changed,
  output logic [NUM_PLAYERS-1:0]                 turn_dropped,
  output logic [NUM_PLAYERS*$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH + 1);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_canal
    cobra_dir_canal #(
      .DEPTH     (DEPTH),
      .RESET_DIR (dir_t'(RESET_DIR)),
      .LW        (LW)
    ) u_canal (
      .clk          (clk),
      .reset        (reset),
      .btn_n        (btn_n[4*p +: 4]),
      .move_tick    (move_tick),
      .dir          (dir[2*p +: 2]),
      .dir_changed  (dir_changed[p]),
      .turn_dropped (turn_dropped[p]),
      .level        (level[LW*p +: LW])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_cobra_dir_fila.sv
// ============================================================================
// Module : tb_cobra_dir_fila
// Brief  : Scoreboard bench for cobra_dir_fila with a shift-queue reference.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cobra_dir_fila;

  localparam int         NP    = 2;
  localparam int         DEPTH = 3;
  localparam logic [1:0] RDIR  = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] btn_n;
  logic       move_tick;
  logic [3:0] dir;
  logic [1:0] dir_changed;
  logic [1:0] turn_dropped;
  logic [3:0] level;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] dir;
    logic [1:0] chg;
    logic [1:0] drop;
    logic [3:0] lvl;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_prev [NP];
  logic [1:0] m_dir  [NP];
  logic [1:0] m_q    [NP][8];
  int         m_cnt  [NP];

  cobra_dir_fila #(
    .NUM_PLAYERS (NP),
    .DEPTH       (DEPTH),
    .RESET_DIR   (RDIR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_n        (btn_n),
    .move_tick    (move_tick),
    .dir          (dir),
    .dir_changed  (dir_changed),
    .turn_dropped (turn_dropped),
    .level        (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: queue kept as a front-aligned shift array, head at index 0.
  function automatic exp_t model_step(input logic [7:0] b, input logic t, input logic r);
    exp_t e;
    e = '0;
    for (int p = 0; p < NP; p++) begin
      logic [3:0] pr;
      logic [1:0] sel, rf;
      logic       ok;
      if (r) begin
        m_prev[p] = 4'hF;
        m_dir[p]  = RDIR;
        m_cnt[p]  = 0;
      end else begin
        pr  = m_prev[p] & ~b[4*p +: 4];
        sel = pr[0] ? 2'd0 : pr[1] ? 2'd1 : pr[2] ? 2'd2 : 2'd3;
        rf  = (m_cnt[p] > 0) ? m_q[p][m_cnt[p]-1] : m_dir[p];
        ok  = (pr != 0) && (sel != rf) && (sel != {rf[1], ~rf[0]}) &&
              ((m_cnt[p] < DEPTH) || t);
        e.drop[p] = (pr != 0) && !ok;
        if (t && m_cnt[p] > 0) begin
          m_dir[p] = m_q[p][0];
          for (int k = 0; k < 7; k++) m_q[p][k] = m_q[p][k+1];
          m_cnt[p]--;
          e.chg[p] = 1'b1;
        end
        if (ok) begin
          m_q[p][m_cnt[p]] = sel;
          m_cnt[p]++;
        end
        m_prev[p] = b[4*p +: 4];
      end
      e.dir[2*p +: 2] = m_dir[p];
      e.lvl[2*p +: 2] = m_cnt[p][1:0];
    end
    return e;
  endfunction

  task automatic cyc(input logic [7:0] b, input logic t, input logic r);
    exp_t e;
    @(negedge clk);
    btn_n     = b;
    move_tick = t;
    reset     = r;
    sb.push_back(model_step(b, t, r));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    for (int p = 0; p < NP; p++) begin
      check($sformatf("dir%0d", p),  int'(dir[2*p +: 2]),   int'(e.dir[2*p +: 2]));
      check($sformatf("chg%0d", p),  int'(dir_changed[p]),  int'(e.chg[p]));
      check($sformatf("drop%0d", p), int'(turn_dropped[p]), int'(e.drop[p]));
      check($sformatf("lvl%0d", p),  int'(level[2*p +: 2]), int'(e.lvl[2*p +: 2]));
    end
  endtask

  task automatic do_reset();
    cyc(8'hFF, 1'b0, 1'b1);
    cyc(8'hFF, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; btn_n = 8'hFF; move_tick = 1'b0;
    do_reset();
    check("rst_dir0", int'(dir[1:0]), 3);
    check("rst_lvl0", int'(level[1:0]), 0);

    // Single turn: queued, then committed on tick.
    cyc(8'hFE, 1'b0, 1'b0);
    check("up_lvl", int'(level[1:0]), 1);
    check("up_dir_hold", int'(dir[1:0]), 3);
    cyc(8'hFF, 1'b1, 1'b0);
    check("tick_dir", int'(dir[1:0]), 0);
    check("tick_chg", int'(dir_changed[0]), 1);
    check("tick_lvl", int'(level[1:0]), 0);

    // Reversal and duplicate against committed dir.
    do_reset();
    cyc(8'hFB, 1'b0, 1'b0);
    check("rev_drop", int'(turn_dropped[0]), 1);
    check("rev_lvl", int'(level[1:0]), 0);
    cyc(8'hF7, 1'b0, 1'b0);
    check("dup_drop", int'(turn_dropped[0]), 1);

    // Reversal against queue tail.
    do_reset();
    cyc(8'hFE, 1'b0, 1'b0);
    cyc(8'hFD, 1'b0, 1'b0);
    check("tail_rev_drop", int'(turn_dropped[0]), 1);
    check("tail_rev_lvl", int'(level[1:0]), 1);

    // up, left, up drain in order.
    do_reset();
    cyc(8'hFE, 1'b0, 1'b0);
    cyc(8'hFB, 1'b0, 1'b0);
    cyc(8'hFE, 1'b0, 1'b0);
    cyc(8'hFF, 1'b1, 1'b0); check("seq_d1", int'(dir[1:0]), 0);
    cyc(8'hFF, 1'b1, 1'b0); check("seq_d2", int'(dir[1:0]), 2);
    cyc(8'hFF, 1'b1, 1'b0); check("seq_d3", int'(dir[1:0]), 0);
    cyc(8'hFF, 1'b1, 1'b0); check("empty_chg", int'(dir_changed[0]), 0);

    // Full queue: drop without tick, accept with tick.
    do_reset();
    cyc(8'hFE, 1'b0, 1'b0); cyc(8'hFB, 1'b0, 1'b0); cyc(8'hFE, 1'b0, 1'b0);
    cyc(8'hFB, 1'b0, 1'b0);
    check("full_drop", int'(turn_dropped[0]), 1);
    check("full_lvl", int'(level[1:0]), 3);
    do_reset();
    cyc(8'hFE, 1'b0, 1'b0); cyc(8'hFB, 1'b0, 1'b0); cyc(8'hFE, 1'b0, 1'b0);
    cyc(8'hFB, 1'b1, 1'b0);
    check("full_tick_drop", int'(turn_dropped[0]), 0);
    check("full_tick_lvl", int'(level[1:0]), 3);
    check("full_tick_dir", int'(dir[1:0]), 0);

    // Held button, then simultaneous presses.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(8'hFD, 1'b0, 1'b0);
    check("hold_lvl", int'(level[1:0]), 1);
    cyc(8'hFF, 1'b1, 1'b0);
    check("hold_dir", int'(dir[1:0]), 1);
    do_reset();
    cyc(8'hFA, 1'b0, 1'b0);
    check("prio_lvl", int'(level[1:0]), 1);
    check("prio_drop", int'(turn_dropped[0]), 0);
    cyc(8'hFF, 1'b1, 1'b0);
    check("prio_dir", int'(dir[1:0]), 0);

    // Reset beats tick with both queues populated.
    do_reset();
    cyc(8'hEE, 1'b0, 1'b0);
    cyc(8'hFB, 1'b0, 1'b0);
    check("pre_lvl0", int'(level[1:0]), 2);
    check("pre_lvl1", int'(level[3:2]), 1);
    cyc(8'hFF, 1'b1, 1'b1);
    check("rst_dir_all", int'(dir), 4'hF);
    check("rst_lvl_all", int'(level), 0);
    check("rst_chg_all", int'(dir_changed), 0);

    // Random traffic exercises pointer wrap and channel independence.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      for (int k = 0; k < 8; k++) b[k] = ($urandom_range(0, 3) != 0);
      cyc(b, ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
